// File: rtl/commit_ctrl_pkg.sv
// rtl/commit_ctrl_pkg.sv - shared types and constants for the in-order commit controller
package commit_ctrl_pkg;

    localparam int ROB_BIT_DEF = 4;

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_STORE  = 2'd1,
        T_BRANCH = 2'd2,
        T_HALT   = 2'd3
    } head_type_e;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_STORE_WAIT = 2'd1,
        S_FLUSH      = 2'd2,
        S_HALTED     = 2'd3
    } commit_state_e;

endpackage

// File: rtl/commit_ctrl_if.sv
// rtl/commit_ctrl_if.sv - ROB head, register file, LSB and fetch signals around the commit controller
interface commit_ctrl_if
    import commit_ctrl_pkg::*;
#(
    parameter int ROB_BIT = ROB_BIT_DEF
);
    logic               head_valid;
    logic               head_ready;
    logic [ROB_BIT-1:0] head_entry;
    logic [1:0]         head_type;
    logic [4:0]         head_rd;
    logic [31:0]        head_value;
    logic               head_mispredict;
    logic [31:0]        head_target;
    logic               rob_pop;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic               store_go;
    logic [ROB_BIT-1:0] store_entry;
    logic               store_done;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               rob_clear_up;
    logic               halt;
    logic [31:0]        instret_cnt;
    logic [31:0]        flush_cnt;

    modport master (
        input  head_valid, head_ready, head_entry, head_type, head_rd, head_value,
               head_mispredict, head_target, store_done,
        output rob_pop, commit_reg_id, commit_reg_data, commit_rob_entry, store_go,
               store_entry, redirect_valid, redirect_pc, rob_clear_up, halt,
               instret_cnt, flush_cnt
    );

    modport slave (
        output head_valid, head_ready, head_entry, head_type, head_rd, head_value,
               head_mispredict, head_target, store_done,
        input  rob_pop, commit_reg_id, commit_reg_data, commit_rob_entry, store_go,
               store_entry, redirect_valid, redirect_pc, rob_clear_up, halt,
               instret_cnt, flush_cnt
    );
endinterface

// File: rtl/commit_perf_cnt.sv
// rtl/commit_perf_cnt.sv - retired-instruction and mispredict counters, wrapping at 2^32
module commit_perf_cnt (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pop,
    input  logic        redirect,
    output logic [31:0] instret_cnt,
    output logic [31:0] flush_cnt
);
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            instret_cnt <= 32'd0;
            flush_cnt   <= 32'd0;
        end else begin
            if (pop)      instret_cnt <= instret_cnt + 32'd1;
            if (redirect) flush_cnt   <= flush_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - in-order commit sequencer; COMMIT_PERF_CNT_EN adds the perf counters
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int ROB_BIT = ROB_BIT_DEF
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    commit_ctrl_if.master bus
);
    commit_state_e      state;
    logic               active;
    logic               head_go;
    logic               pop;
    logic [4:0]         reg_id;
    logic [31:0]        reg_data;
    logic [ROB_BIT-1:0] reg_entry;
    logic               sgo;
    logic [ROB_BIT-1:0] sentry;
    logic               redir;
    logic [31:0]        redir_pc;
    logic               clear;
    logic               halted;
    logic [31:0]        instret;
    logic [31:0]        flushes;

    assign active  = rdy_in && !rst_in;
    assign head_go = bus.head_valid && bus.head_ready;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else if (rdy_in) begin
            case (state)
                S_IDLE: if (head_go) begin
                    case (head_type_e'(bus.head_type))
                        T_STORE:  state <= S_STORE_WAIT;
                        T_BRANCH: if (bus.head_mispredict) state <= S_FLUSH;
                        T_HALT:   state <= S_HALTED;
                        default:  state <= S_IDLE;
                    endcase
                end
                S_STORE_WAIT: if (bus.store_done) state <= S_IDLE;
                S_FLUSH:      state <= S_IDLE;
                default:      state <= S_HALTED;
            endcase
        end
    end

    // Mealy decode: a retiring REG/BRANCH commits in the same cycle it is seen.
    always_comb begin
        pop       = 1'b0;
        reg_id    = 5'd0;
        reg_data  = 32'd0;
        reg_entry = '0;
        sgo       = 1'b0;
        sentry    = '0;
        redir     = 1'b0;
        redir_pc  = 32'd0;
        clear     = 1'b0;
        halted    = 1'b0;
        if (active) begin
            case (state)
                S_IDLE: if (head_go) begin
                    case (head_type_e'(bus.head_type))
                        T_REG, T_BRANCH: begin
                            pop       = 1'b1;
                            reg_id    = bus.head_rd;
                            reg_data  = bus.head_value;
                            reg_entry = bus.head_entry;
                            if (head_type_e'(bus.head_type) == T_BRANCH && bus.head_mispredict) begin
                                redir    = 1'b1;
                                redir_pc = bus.head_target;
                            end
                        end
                        T_STORE: begin
                            sgo    = 1'b1;
                            sentry = bus.head_entry;
                        end
                        default: pop = 1'b1;
                    endcase
                end
                S_STORE_WAIT: pop    = bus.store_done;
                S_FLUSH:      clear  = 1'b1;
                default:      halted = 1'b1;
            endcase
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    commit_perf_cnt u_perf (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .pop         (pop),
        .redirect    (redir),
        .instret_cnt (instret),
        .flush_cnt   (flushes)
    );
`else
    assign instret = 32'd0;
    assign flushes = 32'd0;
`endif

    assign bus.rob_pop          = pop;
    assign bus.commit_reg_id    = reg_id;
    assign bus.commit_reg_data  = reg_data;
    assign bus.commit_rob_entry = reg_entry;
    assign bus.store_go         = sgo;
    assign bus.store_entry      = sentry;
    assign bus.redirect_valid   = redir;
    assign bus.redirect_pc      = redir_pc;
    assign bus.rob_clear_up     = clear;
    assign bus.halt             = halted;
    assign bus.instret_cnt      = active ? instret : 32'd0;
    assign bus.flush_cnt        = active ? flushes : 32'd0;
endmodule
